// File: rtl/demux_large_slot_pkg.sv
// Shared constants, types and helpers for the ten-way 8-bit block distributor.
// The helper decides whether a target index names a real output channel.
package demux_large_pkg;

  localparam int WIDTH   = 8;
  localparam int NUM_OUT = 10;
  localparam int SEL_W   = 4;
  localparam int ERR_W   = 8;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [ERR_W-1:0] err_t;

  function automatic logic is_legal_sel(input sel_t s);
    return (32'(s) < 32'(NUM_OUT));
  endfunction

endpackage

// File: rtl/demux_large_slot_if.sv
// Producer-side stream plus the ten buffered consumer channels of the distributor.
// "master" is the producer/consumer side; "slave" is the distributor itself.
interface demux_large_slot_if;
  import demux_large_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         sel;
  logic                     auto_mode;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, sel, auto_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, sel, auto_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_large_slot_slot.sv
// One-entry output register with valid/ready; a write always wins over a drain,
// so a simultaneous drain+write leaves the slot full with the new block.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (wr_en) begin
      valid_reg <= 1'b1;
      data_reg  <= wr_data;
    end else if (valid_reg && rd_ready) begin
      // Data is left in place after a drain; consumers qualify with valid.
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/demux_large_slot.sv
// Ten-way block distributor: steers one valid/ready stream into ten one-entry
// output slots by explicit select or by a round-robin pointer.
module demux_large_slot
  import demux_large_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  demux_large_slot_if.slave  bus,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic [SEL_W-1:0]   rr_ptr
);

  sel_t               rr_ptr_reg, rr_ptr_next;
  err_t               err_count_reg, err_count_next;
  logic               err_pulse_reg;
  sel_t               tgt;
  logic               tgt_legal;
  logic               in_ready_mux;
  logic               accept;
  logic               drop;
  logic [NUM_OUT-1:0] slot_free;
  logic [NUM_OUT-1:0] wr_en;
  logic [NUM_OUT-1:0] slot_valid;
  data_t              slot_data [NUM_OUT];

  assign tgt       = bus.auto_mode ? rr_ptr_reg : bus.sel;
  assign tgt_legal = is_legal_sel(tgt);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_slot
      assign slot_free[gi] = !slot_valid[gi] | bus.out_ready[gi];
      assign wr_en[gi]     = bus.in_valid & tgt_legal & (tgt == SEL_W'(gi)) & slot_free[gi];

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en[gi]),
        .wr_data  (bus.in_data),
        .rd_ready (bus.out_ready[gi]),
        .valid    (slot_valid[gi]),
        .data     (slot_data[gi])
      );

      assign bus.out_data[gi*WIDTH +: WIDTH] = slot_data[gi];
    end
  endgenerate

  assign bus.out_valid = slot_valid;

  // in_ready depends only on the target and slot state, never on in_valid;
  // an illegal target matches no slot and so reads as always ready.
  always_comb begin
    in_ready_mux = 1'b1;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (tgt == SEL_W'(i)) begin
        in_ready_mux = slot_free[i];
      end
    end
  end

  assign bus.in_ready = in_ready_mux;
  assign accept       = bus.in_valid & in_ready_mux;
  assign drop         = bus.in_valid & !tgt_legal;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept && bus.auto_mode) begin
      rr_ptr_next = (rr_ptr_reg == SEL_W'(NUM_OUT - 1)) ? '0 : rr_ptr_reg + 1'b1;
    end
  end

  always_comb begin
    err_count_next = err_count_reg;
    if (drop && (err_count_reg != '1)) begin
      err_count_next = err_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= drop;
    end
  end

  assign rr_ptr    = rr_ptr_reg;
  assign err_count = err_count_reg;
  assign err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_demux_large_slot.sv
// Bench for demux_large_slot: directed vector table, hand-written corner
// sequences and random traffic compared against a behavioural channel model.
module tb_demux_large_slot;
  import demux_large_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [SEL_W-1:0] rr_ptr;

  demux_large_slot_if bus();

  demux_large_slot dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: ten one-entry mailboxes, a pointer and a drop counter.
  logic       m_valid [NUM_OUT];
  logic [7:0] m_data  [NUM_OUT];
  int         m_rr;
  int         m_ecnt;
  logic       m_ep;
  logic       last_rdy;
  logic       last_acc;

  typedef struct {
    logic       iv;
    logic [3:0] sel;
    logic [7:0] data;
    logic [9:0] ordy;
    logic       e_rdy;
    logic [9:0] e_valid;
    logic [3:0] ch;
    logic [7:0] e_data;
    logic       e_ep;
    logic [7:0] e_ec;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_OUT; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 8'h00;
    end
    m_rr   = 0;
    m_ecnt = 0;
    m_ep   = 1'b0;
  endtask

  function automatic int target(input logic [3:0] s, input logic am);
    return am ? m_rr : int'(s);
  endfunction

  function automatic logic model_ready(input logic [3:0] s, input logic am, input logic [9:0] ordy);
    int t;
    t = target(s, am);
    if (t >= NUM_OUT) return 1'b1;
    return !m_valid[t] || ordy[t];
  endfunction

  task automatic model_step(input logic iv, input logic [3:0] s, input logic am,
                            input logic [7:0] d, input logic [9:0] ordy);
    int   t;
    logic rdy;
    t   = target(s, am);
    rdy = model_ready(s, am, ordy);
    for (int i = 0; i < NUM_OUT; i++) begin
      if (m_valid[i] && ordy[i]) m_valid[i] = 1'b0;
    end
    if (iv && rdy && t < NUM_OUT) begin
      m_valid[t] = 1'b1;
      m_data[t]  = d;
    end
    if (iv && rdy && am) m_rr = (m_rr + 1) % NUM_OUT;
    m_ep = iv && (t >= NUM_OUT);
    if (m_ep && m_ecnt < 255) m_ecnt++;
  endtask

  task automatic check_model();
    logic [9:0]  ev;
    logic [79:0] ed;
    for (int i = 0; i < NUM_OUT; i++) begin
      ev[i]         = m_valid[i];
      ed[i*8 +: 8]  = m_data[i];
    end
    chk("model_out_valid", 80'(bus.out_valid), 80'(ev));
    chk("model_out_data", bus.out_data, ed);
    chk("model_rr_ptr", 80'(rr_ptr), 80'(m_rr));
    chk("model_err_count", 80'(err_count), 80'(m_ecnt));
    chk("model_err_pulse", 80'(err_pulse), 80'(m_ep));
  endtask

  // Drive at posedge+1, check in_ready at negedge, check state at next posedge+1.
  task automatic cycle(input logic iv, input logic [3:0] s, input logic am,
                       input logic [7:0] d, input logic [9:0] ordy);
    logic exp_rdy;
    bus.in_valid  = iv;
    bus.sel       = s;
    bus.auto_mode = am;
    bus.in_data   = d;
    bus.out_ready = ordy;
    exp_rdy = model_ready(s, am, ordy);
    @(negedge clk);
    chk("model_in_ready", 80'(bus.in_ready), 80'(exp_rdy));
    last_rdy = bus.in_ready;
    last_acc = iv & bus.in_ready;
    @(posedge clk);
    model_step(iv, s, am, d, ordy);
    #1;
    check_model();
  endtask

  function automatic logic [7:0] ch_data(input int ch);
    logic [79:0] v;
    v = bus.out_data;
    return v[ch*8 +: 8];
  endfunction

  initial begin
    int stalls;
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.auto_mode = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    model_reset();

    vecs[0]  = '{1'b1, 4'd3,  8'h5A, 10'h000, 1'b1, 10'h008, 4'd3, 8'h5A, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'd3,  8'h77, 10'h000, 1'b0, 10'h008, 4'd3, 8'h5A, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 4'd3,  8'h77, 10'h008, 1'b1, 10'h008, 4'd3, 8'h77, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 4'd3,  8'h00, 10'h008, 1'b1, 10'h000, 4'd3, 8'h77, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 4'd12, 8'hEE, 10'h000, 1'b1, 10'h000, 4'd3, 8'h77, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 4'd12, 8'hEE, 10'h000, 1'b1, 10'h000, 4'd3, 8'h77, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 4'd7,  8'h11, 10'h000, 1'b1, 10'h080, 4'd7, 8'h11, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 4'd7,  8'hC3, 10'h080, 1'b1, 10'h080, 4'd7, 8'hC3, 1'b0, 8'd1};
    vecs[8]  = '{1'b1, 4'd12, 8'h00, 10'h000, 1'b1, 10'h080, 4'd7, 8'hC3, 1'b1, 8'd2};
    vecs[9]  = '{1'b1, 4'd15, 8'h00, 10'h000, 1'b1, 10'h080, 4'd7, 8'hC3, 1'b1, 8'd3};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 10'h000, 1'b1, 10'h080, 4'd7, 8'hC3, 1'b0, 8'd3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 80'(bus.out_valid), 80'h0);
    chk("reset_out_data", bus.out_data, 80'h0);
    chk("reset_rr_ptr", 80'(rr_ptr), 80'h0);
    chk("reset_err_count", 80'(err_count), 80'h0);
    chk("reset_err_pulse", 80'(err_pulse), 80'h0);
    chk("reset_in_ready", 80'(bus.in_ready), 80'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int v = 0; v < 11; v++) begin
      cycle(vecs[v].iv, vecs[v].sel, 1'b0, vecs[v].data, vecs[v].ordy);
      chk($sformatf("vec%0d_in_ready", v), 80'(last_rdy), 80'(vecs[v].e_rdy));
      chk($sformatf("vec%0d_out_valid", v), 80'(bus.out_valid), 80'(vecs[v].e_valid));
      chk($sformatf("vec%0d_ch_data", v), 80'(ch_data(int'(vecs[v].ch))), 80'(vecs[v].e_data));
      chk($sformatf("vec%0d_err_pulse", v), 80'(err_pulse), 80'(vecs[v].e_ep));
      chk($sformatf("vec%0d_err_count", v), 80'(err_count), 80'(vecs[v].e_ec));
    end

    // Round-robin burst of 12 blocks with every consumer ready
    stalls = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 4'd0, 1'b1, 8'(k), 10'h3FF);
      if (!last_acc) stalls++;
    end
    chk("rr_burst_stalls", 80'(stalls), 80'h0);
    chk("rr_burst_ptr", 80'(rr_ptr), 80'h2);
    chk("rr_burst_ch0", 80'(ch_data(0)), 80'h0A);
    chk("rr_burst_ch1", 80'(ch_data(1)), 80'h0B);
    chk("rr_burst_ch7", 80'(ch_data(7)), 80'h07);
    chk("rr_burst_ch9", 80'(ch_data(9)), 80'h09);
    chk("rr_burst_valid", 80'(bus.out_valid), 80'h002);

    // Error counter saturation
    for (int k = 0; k < 300; k++) cycle(1'b1, 4'd12, 1'b0, 8'hFF, 10'h000);
    chk("err_saturate", 80'(err_count), 80'd255);
    cycle(1'b0, 4'd12, 1'b0, 8'h00, 10'h000);
    chk("err_pulse_ends", 80'(err_pulse), 80'h0);

    // Stalled auto channel blocks input; manual select still works
    cycle(1'b1, 4'd4, 1'b0, 8'h44, 10'h000);
    cycle(1'b1, 4'd0, 1'b1, 8'h22, 10'h000);
    cycle(1'b1, 4'd0, 1'b1, 8'h33, 10'h000);
    chk("stall_setup_ptr", 80'(rr_ptr), 80'h4);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'd0, 1'b1, 8'h99, 10'h000);
      chk("stall_in_ready", 80'(last_rdy), 80'h0);
      chk("stall_ptr_hold", 80'(rr_ptr), 80'h4);
      chk("stall_ch4_held", 80'(ch_data(4)), 80'h44);
    end
    cycle(1'b1, 4'd8, 1'b0, 8'h88, 10'h000);
    chk("manual_accept", 80'(last_acc), 80'h1);
    chk("manual_ch8_valid", 80'(bus.out_valid[8]), 80'h1);
    chk("manual_ch8_data", 80'(ch_data(8)), 80'h88);
    chk("manual_ptr_hold", 80'(rr_ptr), 80'h4);

    // Asynchronous reset mid-stream with several slots full
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 80'(bus.out_valid), 80'h0);
    chk("async_rst_out_data", bus.out_data, 80'h0);
    chk("async_rst_rr_ptr", 80'(rr_ptr), 80'h0);
    chk("async_rst_err_count", 80'(err_count), 80'h0);
    chk("async_rst_err_pulse", 80'(err_pulse), 80'h0);
    chk("async_rst_in_ready", 80'(bus.in_ready), 80'h1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'd0, 1'b0, 8'h5C, 10'h000);
    chk("post_rst_latency_valid", 80'(bus.out_valid), 80'h001);
    chk("post_rst_latency_data", 80'(ch_data(0)), 80'h5C);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            8'($urandom), 10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
